// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back arbiter and its result queue.
package wb_pkg;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int NREG   = 32;

   // One queued mul/div result; a dead entry drains without touching the RF.
   typedef struct packed {
      logic              live;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] wd;
   } wb_entry_t;

   // Register-number to scoreboard mask; r0 is never reported busy.
   function automatic logic [NREG-1:0] rd_onehot(input logic [REG_W-1:0] rd);
      logic [NREG-1:0] m;
      m     = '0;
      m[rd] = 1'b1;
      m[0]  = 1'b0;
      return m;
   endfunction
endpackage

// File: rtl/wb_fifo.sv
// Mul/div result queue: circular buffer with per-entry live bits, kill-by-rd
// and a flat view of live/rd for the busy scoreboard.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_push,
   input  wb_entry_t                   i_push_entry,
   input  logic                        i_pop,
   input  logic                        i_kill,
   input  logic [REG_W-1:0]            i_kill_rd,
   output wb_entry_t                   o_head,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [DEPTH-1:0]            o_live,
   output logic [DEPTH-1:0][REG_W-1:0] o_rd
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0]              r_live;
   logic [DEPTH-1:0][REG_W-1:0]   r_rd;
   logic [DEPTH-1:0][DATA_W-1:0]  r_wd;
   logic [PTR_W-1:0]              r_head;
   logic [PTR_W-1:0]              r_tail;
   logic [CNT_W-1:0]              r_count;
   logic                          w_push;
   logic                          w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = '{live: r_live[r_head], rd: r_rd[r_head], wd: r_wd[r_head]};
   assign o_live  = r_live;
   assign o_rd    = r_rd;

   // Control state: pointers, occupancy and live bits (kill, then pop, then push).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_kill && (r_rd[i] == i_kill_rd)) r_live[i] <= 1'b0;
         end
         if (w_pop)  r_live[r_head] <= 1'b0;
         if (w_push) r_live[r_tail] <= i_push_entry.live;
         if (w_pop)  r_head <= r_head + 1'b1;
         if (w_push) r_tail <= r_tail + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage is written on push only; live bits guard stale contents.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rd[r_tail] <= i_push_entry.rd;
         r_wd[r_tail] <= i_push_entry.wd;
      end
   end
endmodule

// File: rtl/wb_arb.sv
// Write-back arbiter: pipeline write-back has priority over queued mul/div
// results on the single RF write port; exports a per-register busy scoreboard.
module wb_arb
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p_valid,
   input  logic [REG_W-1:0]  p_rd,
   input  logic [DATA_W-1:0] p_wd,
   input  logic              m_valid,
   output logic              m_ready,
   input  logic [REG_W-1:0]  m_rd,
   input  logic [DATA_W-1:0] m_wd,
   output logic              rf_wr,
   output logic [REG_W-1:0]  rf_a3,
   output logic [DATA_W-1:0] rf_wd,
   output logic [NREG-1:0]   busy
);
   logic                        r_rf_wr;
   logic [REG_W-1:0]            r_rf_a3;
   logic [DATA_W-1:0]           r_rf_wd;
   logic                        w_p_own;
   logic                        w_push;
   logic                        w_pop;
   logic                        w_full;
   logic                        w_empty;
   wb_entry_t                   w_head;
   wb_entry_t                   w_push_entry;
   logic [DEPTH-1:0]            w_live;
   logic [DEPTH-1:0][REG_W-1:0] w_rd;

   // P owns the port whenever it targets a real register.
   assign w_p_own = p_valid && (p_rd != '0);
   assign m_ready = !w_full;
   // r0 results complete the handshake but are never stored.
   assign w_push  = m_valid && !w_full && (m_rd != '0);
   // An M result overwritten by a concurrent (younger) P write enters dead.
   assign w_push_entry = '{live: !(w_p_own && (m_rd == p_rd)), rd: m_rd, wd: m_wd};
   // Dead heads drain regardless of P; live heads wait for a free port.
   assign w_pop   = !w_empty && (!w_head.live || !w_p_own);

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .i_kill       (w_p_own),
      .i_kill_rd    (p_rd),
      .o_head       (w_head),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_live       (w_live),
      .o_rd         (w_rd)
   );

   // Registered RF write port; address/data hold when no write is selected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_wr <= 1'b0;
         r_rf_a3 <= '0;
         r_rf_wd <= '0;
      end else if (w_p_own) begin
         r_rf_wr <= 1'b1;
         r_rf_a3 <= p_rd;
         r_rf_wd <= p_wd;
      end else if (w_pop && w_head.live) begin
         r_rf_wr <= 1'b1;
         r_rf_a3 <= w_head.rd;
         r_rf_wd <= w_head.wd;
      end else begin
         r_rf_wr <= 1'b0;
      end
   end

   assign rf_wr = r_rf_wr;
   assign rf_a3 = r_rf_a3;
   assign rf_wd = r_rf_wd;

   // Busy scoreboard: OR of live queued destinations.
   always_comb begin
      busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_live[i]) busy = busy | rd_onehot(w_rd[i]);
      end
   end
endmodule

// File: tb/tb_wb_arb.sv
// Bench for wb_arb: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the arbitration rules.
module tb_wb_arb;
   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        p_valid;
   logic [4:0]  p_rd;
   logic [31:0] p_wd;
   logic        m_valid;
   logic        m_ready;
   logic [4:0]  m_rd;
   logic [31:0] m_wd;
   logic        rf_wr;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd;
   logic [31:0] busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit       live;
      int       rd;
      bit [31:0] wd;
   } ent_t;

   ent_t      q[$];
   bit        e_wr;
   bit [4:0]  e_a3;
   bit [31:0] e_wd;

   wb_arb #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .p_valid (p_valid),
      .p_rd    (p_rd),
      .p_wd    (p_wd),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_rd    (m_rd),
      .m_wd    (m_wd),
      .rf_wr   (rf_wr),
      .rf_a3   (rf_a3),
      .rf_wd   (rf_wd),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] model_busy();
      bit [31:0] b;
      b = '0;
      foreach (q[i]) if (q[i].live && q[i].rd != 0) b[q[i].rd] = 1'b1;
      return b;
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ".rf_wr"}, rf_wr, e_wr);
      chk({tag, ".rf_a3"}, rf_a3, e_a3);
      chk({tag, ".rf_wd"}, rf_wd, e_wd);
      chk({tag, ".busy"}, busy, model_busy());
      chk({tag, ".m_ready"}, m_ready, (q.size() < DEPTH));
   endtask

   // One clock cycle: drive at negedge, advance the model, check after the edge.
   task automatic step(input string tag, input bit pv, input int prd, input bit [31:0] pwd,
                       input bit mv, input int mrd, input bit [31:0] mwd);
      bit   p_own, xfer, do_pop, pop_live;
      ent_t head;
      @(negedge clk);
      p_valid = pv; p_rd = prd[4:0]; p_wd = pwd;
      m_valid = mv; m_rd = mrd[4:0]; m_wd = mwd;
      p_own    = pv && (prd != 0);
      xfer     = mv && (q.size() < DEPTH);
      do_pop   = (q.size() > 0) && (!q[0].live || !p_own);
      pop_live = 1'b0;
      if (do_pop) begin
         head     = q[0];
         pop_live = head.live;
      end
      if (p_own) foreach (q[i]) if (q[i].rd == prd) q[i].live = 1'b0;
      if (do_pop) void'(q.pop_front());
      if (xfer && mrd != 0) q.push_back('{live: !(p_own && mrd == prd), rd: mrd, wd: mwd});
      if (p_own) begin
         e_wr = 1'b1; e_a3 = prd[4:0]; e_wd = pwd;
      end else if (pop_live) begin
         e_wr = 1'b1; e_a3 = head.rd[4:0]; e_wd = head.wd;
      end else begin
         e_wr = 1'b0;
      end
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic idle_inputs();
      p_valid = 1'b0; p_rd = '0; p_wd = '0;
      m_valid = 1'b0; m_rd = '0; m_wd = '0;
   endtask

   // Asynchronous reset mid-cycle, checked before release.
   task automatic do_reset(input string tag);
      @(negedge clk);
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      chk({tag, ".rf_wr"}, rf_wr, 1'b0);
      chk({tag, ".rf_a3"}, rf_a3, 5'd0);
      chk({tag, ".rf_wd"}, rf_wd, 32'd0);
      chk({tag, ".m_ready"}, m_ready, 1'b1);
      chk({tag, ".busy"}, busy, 32'd0);
      q.delete();
      e_wr = 1'b0; e_a3 = '0; e_wd = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_model({tag, ".post"});
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      q.delete();
      e_wr = 1'b0; e_a3 = '0; e_wd = '0;

      do_reset("rst0");

      // P path
      step("p5", 1, 5, 32'h0000_1234, 0, 0, 0);
      chk("p5.wr", rf_wr, 1'b1);
      chk("p5.a3", rf_a3, 5'd5);
      chk("p5.wd", rf_wd, 32'h0000_1234);
      step("p_idle", 0, 0, 0, 0, 0, 0);
      chk("p_idle.wr", rf_wr, 1'b0);

      // M path
      step("m7", 0, 0, 0, 1, 7, 32'hCAFE_F00D);
      chk("m7.busy7", busy[7], 1'b1);
      step("m7_pop", 0, 0, 0, 0, 0, 0);
      chk("m7_pop.wr", rf_wr, 1'b1);
      chk("m7_pop.a3", rf_a3, 5'd7);
      chk("m7_pop.wd", rf_wd, 32'hCAFE_F00D);
      chk("m7_pop.busy7", busy[7], 1'b0);

      // Contention until full, then drain in order
      for (int i = 1; i <= 4; i++) step("fill", 1, 20, 32'h100 + i, 1, i, 32'hA0 + i);
      chk("full.m_ready", m_ready, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         step("drain", 0, 0, 0, 0, 0, 0);
         chk("drain.wr", rf_wr, 1'b1);
         chk("drain.a3", rf_a3, i);
         if (i == 1) chk("drain.m_ready", m_ready, 1'b1);
      end

      // WAW kill
      step("waw_q", 1, 20, 32'h55, 1, 9, 32'h1);
      chk("waw_q.busy9", busy[9], 1'b1);
      step("waw_p", 1, 9, 32'hA, 0, 0, 0);
      chk("waw_p.busy9", busy[9], 1'b0);
      chk("waw_p.a3", rf_a3, 5'd9);
      chk("waw_p.wd", rf_wd, 32'hA);
      step("waw_dead", 0, 0, 0, 0, 0, 0);
      chk("waw_dead.wr", rf_wr, 1'b0);
      chk("waw_dead.wd", rf_wd, 32'hA);
      step("waw_after", 0, 0, 0, 0, 0, 0);

      // r0 on both ports
      step("r0", 1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
      chk("r0.wr", rf_wr, 1'b0);
      chk("r0.m_ready", m_ready, 1'b1);
      chk("r0.busy", busy, 32'd0);

      // Reset mid-drain with 3 entries queued
      for (int i = 1; i <= 4; i++) step("pre_rst", 1, 21, 32'h200 + i, 1, 10 + i, 32'h300 + i);
      step("pre_rst_drain", 0, 0, 0, 0, 0, 0);
      chk("pre_rst.qlen", q.size(), 3);
      do_reset("rst_mid");
      for (int i = 0; i < 4; i++) begin
         step("post_rst", 0, 0, 0, 0, 0, 0);
         chk("post_rst.wr", rf_wr, 1'b0);
      end

      // Random traffic over a small register range to force collisions
      for (int n = 0; n < 400; n++) begin
         step("rand", ($urandom_range(0, 99) < 45), $urandom_range(0, 7), $urandom,
              ($urandom_range(0, 99) < 55), $urandom_range(0, 7), $urandom);
      end
      for (int n = 0; n < 2 * DEPTH; n++) step("flush", 0, 0, 0, 0, 0, 0);
      chk("flush.busy", busy, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_arb.md
# wb_arb

Write-back arbiter that drives the single register-file write port (`RFWr`/`A3`/`WD`). It merges two producers:
- the in-order pipeline write-back stage, which is never stalled;
- the multicycle mul/div unit, whose results are buffered in a small queue.

It also exports a per-register pending scoreboard so the hazard unit can stall readers of registers whose results are still queued.

## Interface
Parameters:
- `DEPTH`, 4: mul/div result queue entries (power of two, 2..8).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `p_valid`  in  1  pipeline write-back request. Always accepted; no ready signal.
- `p_rd`  in  5  pipeline destination register.
- `p_wd`  in  32  pipeline write data.
- `m_valid`  in  1  mul/div result valid.
- `m_ready`  out  1  queue can accept an entry. Transfer happens on a rising edge with `m_valid & m_ready`.
- `m_rd`  in  5  mul/div destination register.
- `m_wd`  in  32  mul/div result.
- `rf_wr`  out  1  to RF `RFWr`.
- `rf_a3`  out  5  to RF `A3`.
- `rf_wd`  out  32  to RF `WD`.
- `busy`  out  32  bit r set while a live queued entry targets register r.

## Operation
- Requests with rd == 0 are discarded on both ports.
  - P: no `rf_wr`.
  - M: the handshake completes, but nothing is enqueued.
- Priority: a valid P request with rd != 0 always owns the write port that cycle.
- Queue: FIFO of {live, rd, wd}.
  - Push on an M transfer.
  - Pop the head when the head is dead, or when the head is live and P does not own the port.
  - A live popped head is driven to the RF.
  - A dead head pops without a write.
  - At most one pop per cycle.
- WAW kill: the hazard unit guarantees any queued or incoming M result is older in program order than a concurrent P request. So a P request to rd clears `live` on every queued entry with the same rd, and an M entry pushed in the same cycle with the same rd is enqueued dead.
- `busy[r]` is the combinational OR over all queue entries of (`live` && rd == r).
  - `busy[0]` is always 0.
  - A popped entry no longer contributes.
- `m_ready` = queue not full, computed from the registered count. A full queue deasserts `m_ready` even if a pop occurs that cycle; there is no pass-through.
- Simultaneous push and pop: count is unchanged; the head and tail pointers both advance (wrap modulo `DEPTH`).

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - `rf_wr`=0, `rf_a3`=0, `rf_wd`=0.
  - Queue emptied: all live bits 0, pointers 0, count 0.
  - Resulting outputs: `m_ready`=1, `busy`=0.
- Reset mid-operation discards all queued results with no RF write.
- `rf_wr`/`rf_a3`/`rf_wd` are registered.
  - A request selected during a cycle appears after that cycle's rising edge.
  - The RF commits it on the following falling edge.
  - When no write is selected, `rf_wr` is 0; `rf_a3`/`rf_wd` hold their last values.
- P latency: `p_valid` sampled at edge E gives `rf_wr`=1 immediately after E.
- M latency: push at edge E into an empty queue, with P idle in the next cycle, gives `rf_wr`=1 after edge E+1.
- `busy` timing for an M entry:
  - `busy[rd]` rises right after the push edge E.
  - It falls right after the pop edge, i.e. the edge at which `rf_wr` for that entry rises.
  - The RF value is readable from that cycle's falling edge.
- A P kill takes effect at the edge that samples P: `busy[rd]` drops after that edge.

## Structure
- Package `wb_pkg`:
  - `REG_W`=5, `DATA_W`=32;
  - typedef `wb_entry_t` {live, rd, wd};
  - function `rd_onehot(rd)` → 32-bit mask with bit 0 forced to 0.
- Sub-module `wb_fifo`:
  - DEPTH-entry storage, pointers, count, full/empty;
  - kill-by-rd input;
  - per-entry rd/live view for the scoreboard.
- The top level holds priority selection, the output registers and the busy OR-reduction.

## Test plan
- Reset: assert `rst_n`=0 mid-drain with 3 entries queued.
  - Expect `rf_wr`=0, `rf_a3`=0, `rf_wd`=0, `m_ready`=1, `busy`=0.
  - No RF write after release.
- P path: P rd=5 wd=0x00001234 at edge E.
  - Expect `rf_wr`=1, `rf_a3`=5, `rf_wd`=0x00001234 after E.
  - Expect `rf_wr`=0 after E+1 when P is idle.
- M path: M rd=7 wd=0xCAFEF00D pushed at E, P idle.
  - Expect `busy[7]`=1 after E.
  - After E+1 expect `rf_wr`=1, `rf_a3`=7, `busy[7]`=0.
- Contention/full:
  - Push 4 M entries (rd=1..4) while P writes rd=20 every cycle. Expect `m_ready`=0 after the 4th push.
  - Then idle P. Expect RF writes in order 1, 2, 3, 4 on consecutive edges, and `m_ready`=1 after the first pop.
- WAW kill: queued M rd=9 wd=0x1, then P rd=9 wd=0xA.
  - Expect exactly one RF write to r9, with value 0xA.
  - Expect `busy[9]`=0 after the P edge.
  - Expect the dead entry to pop later without `rf_wr`.
- r0: P rd=0 and M rd=0 in the same cycle.
  - Expect no `rf_wr`, queue count unchanged, `m_ready` held 1.
